// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: a DEPTH-entry FIFO of {pc, inst}
// with flush for branch redirects and a forced-NOP head when empty.
module inst_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_inst,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_inst,
    input  logic                       out_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_push;
    logic          w_pop;
    logic [63:0]   w_head;

    // in_ready looks only at registered occupancy, so a full queue never
    // accepts a push even when decode pops in the same cycle.
    assign in_ready  = (r_count != CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign count     = r_count;

    assign w_push = in_valid  & in_ready  & ~flush;
    assign w_pop  = out_valid & out_ready & ~flush;

    assign w_head   = r_mem[r_rd_ptr];
    assign out_pc   = out_valid ? w_head[63:32] : 32'h0;
    assign out_inst = out_valid ? w_head[31:0]  : 32'h0;

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_pc, in_inst};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; SHALL be a power of two, minimum 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 in_valid  input  1  fetch stage presents a fetched instruction this cycle.
REQ-005 in_pc  input  32  PC of the presented instruction.
REQ-006 in_inst  input  32  presented instruction word.
REQ-007 in_ready  output  1  queue accepts a push this cycle; fetch stage holds PC when low.
REQ-008 out_valid  output  1  head entry is valid for decode.
REQ-009 out_pc  output  32  PC of head entry.
REQ-010 out_inst  output  32  instruction word of head entry.
REQ-011 out_ready  input  1  decode stage consumes the head entry this cycle.
REQ-012 flush  input  1  branch/jump redirect; discard all queued instructions.
REQ-013 count  output  clog2(DEPTH)+1  number of valid entries, 0..DEPTH.

Function
REQ-014 Storage SHALL be DEPTH entries of {pc[31:0], inst[31:0]}, with a write pointer, a read pointer and an occupancy counter.
REQ-015 Push SHALL occur when in_valid=1 and in_ready=1 and flush=0; entry is written at the write pointer, which then increments.
REQ-016 Pop SHALL occur when out_valid=1 and out_ready=1 and flush=0; the read pointer increments.
REQ-017 Pointers SHALL wrap modulo DEPTH (entry DEPTH-1 -> entry 0).
REQ-018 count SHALL update as follows: +1 on push only; -1 on pop only; unchanged on simultaneous push and pop.
REQ-019 in_ready SHALL be 1 iff count < DEPTH, derived from registered state only, with no combinational path from out_ready.
REQ-020 When full, a same-cycle pop SHALL NOT enable a push; in_ready stays 0 that cycle.
REQ-021 out_valid SHALL be 1 iff count != 0.
REQ-022 out_pc/out_inst SHALL present the entry at the read pointer combinationally from storage.
REQ-023 When count=0, out_pc and out_inst SHALL be forced to 32'h0, so that a NOP is presented.
REQ-024 No bypass: a pushed instruction SHALL become visible on out_* no earlier than the cycle after the push (latency 1 cycle when empty).
REQ-025 On a simultaneous push and pop with count=1, the new entry SHALL become head next cycle; out_valid stays 1.
REQ-026 flush=1 SHALL, on the next edge, set both pointers to 0 and count to 0.
REQ-027 Flush SHALL take priority over push and pop issued in the same cycle; both are discarded.
REQ-028 Combinational outputs SHALL continue to reflect pre-flush state during the flush cycle.
REQ-029 Order SHALL be strictly FIFO; no entry is duplicated or skipped across wrap-around.
REQ-030 Push with in_valid=1 while in_ready=0 SHALL have no effect on state.

Reset
REQ-031 rst=0 SHALL immediately, without waiting for a clock edge, clear both pointers and count to 0.
REQ-032 During and after reset: out_valid=0, out_pc=0, out_inst=0, count=0, in_ready=1.
REQ-033 Reset asserted mid-operation SHALL discard all entries; storage contents need not be cleared.
REQ-034 First push SHALL be accepted on the first rising edge after rst returns to 1.

Verification
REQ-035 Reset then idle -> out_valid=0, out_inst=0, in_ready=1, count=0.
REQ-036 Push PC 0x0,0x4,0x8,0xC with out_ready=0 -> count=4, in_ready=0; a fifth push (0x10) is ignored; then drain with out_ready=1 -> out_pc 0x0,0x4,0x8,0xC on consecutive cycles, then out_valid=0.
REQ-037 Continuous push and pop for 10 cycles, PCs 0x100+4k -> count stays 1, out_pc sequence strictly increments by 4 across pointer wrap.
REQ-038 With 3 entries queued, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0; the following push of PC 0x2000 appears as head one cycle later.
REQ-039 With 2 entries queued, drive rst=0 between clock edges -> out_valid=0 and count=0 immediately; after release, queue operates from empty.
REQ-040 Empty queue, single push of inst 0x20080005 at PC 0x40 -> out_valid=0 in the push cycle; next cycle out_valid=1, out_pc=0x40, out_inst=0x20080005.
